// File: rtl/pipemem_lsu_pkg.sv
// Shared encodings for the pipemem_lsu MEM-stage load/store unit:
// access sizes, FSM states and the fixed data width.
package pipemem_lsu_pkg;

  localparam int DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } lsu_state_e;

  // The unused size code 2'b11 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/pipemem_lsu_align.sv
// Big-endian lane extraction (with sign/zero extension) and sub-word merge
// for pipemem_lsu; purely combinational.
module pipemem_lsu_align
  import pipemem_lsu_pkg::*;
(
  input  logic [DW-1:0] i_old_word,
  input  logic [1:0]    i_addr_lo,
  input  logic [1:0]    i_size,
  input  logic          i_unsigned,
  input  logic [DW-1:0] i_store_data,
  output logic [DW-1:0] o_load_data,
  output logic [DW-1:0] o_merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte offset 0 and half offset 0 both sit at the most significant end.
  always_comb begin
    w_byte        = 8'h00;
    w_half        = 16'h0000;
    o_load_data   = {DW{1'b0}};
    o_merged_word = i_old_word;

    case (i_addr_lo)
      2'b00:   w_byte = i_old_word[31:24];
      2'b01:   w_byte = i_old_word[23:16];
      2'b10:   w_byte = i_old_word[15:8];
      2'b11:   w_byte = i_old_word[7:0];
      default: w_byte = 8'h00;
    endcase

    if (i_addr_lo[1]) begin
      w_half = i_old_word[15:0];
    end else begin
      w_half = i_old_word[31:16];
    end

    case (i_size)
      SZ_BYTE: begin
        o_load_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        case (i_addr_lo)
          2'b00:   o_merged_word[31:24] = i_store_data[7:0];
          2'b01:   o_merged_word[23:16] = i_store_data[7:0];
          2'b10:   o_merged_word[15:8]  = i_store_data[7:0];
          2'b11:   o_merged_word[7:0]   = i_store_data[7:0];
          default: o_merged_word        = i_old_word;
        endcase
      end
      SZ_HALF: begin
        o_load_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
        if (i_addr_lo[1]) begin
          o_merged_word[15:0] = i_store_data[15:0];
        end else begin
          o_merged_word[31:16] = i_store_data[15:0];
        end
      end
      default: begin
        o_load_data   = i_old_word;
        o_merged_word = i_store_data;
      end
    endcase
  end

endmodule

// File: rtl/pipemem_lsu.sv
// MEM-stage load/store initiator driving a synchronous word RAM without byte
// enables. Optional misalignment trap: define PIPEMEM_LSU_MISALIGN_EN.
module pipemem_lsu #(
  parameter int AW = 5,
  parameter int DW = pipemem_lsu_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_misalign,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  import pipemem_lsu_pkg::*;

  lsu_state_e    r_state;
  lsu_state_e    w_next_state;

  logic          r_we;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [1:0]    r_addr_lo;
  logic          r_misalign;

  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_resp_valid;
  logic [DW-1:0] r_resp_rdata;
  logic          r_resp_misalign;

  logic          w_accept;
  logic          w_word_store;
  logic          w_req_misalign;
  logic [DW-1:0] w_load_data;
  logic [DW-1:0] w_merged_word;
  logic          w_unused_addr;

  assign w_accept      = req_valid & (r_state == ST_IDLE);
  assign w_word_store  = req_we & is_word(req_size);
  assign w_unused_addr = ^req_addr[31:AW+2];

`ifdef PIPEMEM_LSU_MISALIGN_EN
  // Flag halves on odd addresses and words off a 4-byte boundary.
  always_comb begin
    w_req_misalign = 1'b0;
    if (is_word(req_size)) begin
      w_req_misalign = (req_addr[1:0] != 2'b00);
    end else if (req_size == SZ_HALF) begin
      w_req_misalign = req_addr[0];
    end else begin
      w_req_misalign = 1'b0;
    end
  end
`else
  assign w_req_misalign = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next_state = ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_misalign) begin
          w_next_state = ST_DONE;
        end else if (r_we & is_word(r_size)) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_we) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      ST_WRITE: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Request attributes captured at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_addr_lo  <= 2'b00;
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr_lo  <= req_addr[1:0];
      r_misalign <= w_req_misalign;
    end
  end

  // RAM and response outputs, all registered so mem_we cannot glitch.
  // mem_wdata holds the raw store data until WAIT replaces it with the merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we        <= 1'b0;
      r_mem_addr      <= {AW{1'b0}};
      r_mem_wdata     <= {DW{1'b0}};
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= {DW{1'b0}};
      r_resp_misalign <= 1'b0;
    end else begin
      r_mem_we     <= 1'b0;
      r_resp_valid <= (w_next_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mem_addr      <= req_addr[AW+1:2];
            r_mem_wdata     <= req_wdata;
            r_mem_we        <= w_word_store & ~w_req_misalign;
            r_resp_rdata    <= {DW{1'b0}};
            r_resp_misalign <= w_req_misalign;
          end
        end
        ST_WAIT: begin
          if (r_we) begin
            r_mem_wdata <= w_merged_word;
            r_mem_we    <= 1'b1;
          end else begin
            r_resp_rdata <= w_load_data;
          end
        end
        default: r_mem_we <= 1'b0;
      endcase
    end
  end

  pipemem_lsu_align u_align (
    .i_old_word    (mem_rdata),
    .i_addr_lo     (r_addr_lo),
    .i_size        (r_size),
    .i_unsigned    (r_unsigned),
    .i_store_data  (r_mem_wdata),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged_word)
  );

  assign req_ready     = (r_state == ST_IDLE);
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_misalign = r_resp_misalign;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_pipemem_lsu.sv
// Self-checking bench for pipemem_lsu: directed cases plus randomized traffic
// against a word-array reference model of the RAM.
module tb_pipemem_lsu;

  localparam int AW = 5;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  pipemem_lsu #(.AW(AW), .DW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    int          idx, sh, lat_exp, we_cyc_exp, lat_obs, we_cnt, we_cyc, resp_cnt, guard;
    logic        mis_exp, mis_obs, we_exp;
    logic [31:0] old, mask, lane, new_word, rd_exp, rd_obs, we_data_obs;
    logic [AW-1:0] we_addr_obs;
    logic        rdy [1:9];

    idx  = int'(addr[AW+1:2]);
    old  = ref_mem[idx];
    mis_exp = 1'b0;
`ifdef PIPEMEM_LSU_MISALIGN_EN
    if (sz == 2'b01) mis_exp = addr[0];
    else if (sz[1]) mis_exp = (addr[1:0] != 2'b00);
`endif
    if (sz == 2'b00) begin
      sh = 8 * (3 - int'(addr[1:0]));
      mask = 32'h0000_00FF << sh;
    end else if (sz == 2'b01) begin
      sh = addr[1] ? 0 : 16;
      mask = 32'h0000_FFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFF_FFFF;
    end
    lane = (old & mask) >> sh;
    if (!uns && sz == 2'b00 && lane[7])  lane = lane | 32'hFFFF_FF00;
    if (!uns && sz == 2'b01 && lane[15]) lane = lane | 32'hFFFF_0000;
    new_word = (old & ~mask) | ((wd << sh) & mask);

    we_cyc_exp = 0;
    if (mis_exp) begin
      lat_exp = 2; we_exp = 1'b0; rd_exp = 32'h0;
    end else if (we) begin
      lat_exp = sz[1] ? 2 : 4;
      we_cyc_exp = sz[1] ? 1 : 3;
      we_exp = 1'b1; rd_exp = 32'h0;
      ref_mem[idx] = new_word;
    end else begin
      lat_exp = 3; we_exp = 1'b0; rd_exp = lane;
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check_val("accept_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);

    lat_obs = 0; we_cnt = 0; we_cyc = 0; resp_cnt = 0;
    rd_obs = 32'h0; mis_obs = 1'b0; we_addr_obs = '0; we_data_obs = 32'h0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      rdy[c] = req_ready;
      if (mem_we) begin
        we_cnt++; we_cyc = c; we_addr_obs = mem_addr; we_data_obs = mem_wdata;
      end
      if (resp_valid) begin
        resp_cnt++;
        if (lat_obs == 0) begin
          lat_obs = c; rd_obs = resp_rdata; mis_obs = resp_misalign;
        end
      end
    end

    check_val("resp_latency", 32'(lat_obs), 32'(lat_exp));
    check_val("resp_pulses", 32'(resp_cnt), 32'h1);
    check_val("resp_rdata", rd_obs, rd_exp);
    check_val("resp_misalign", {31'd0, mis_obs}, {31'd0, mis_exp});
    check_val("we_pulses", 32'(we_cnt), {31'd0, we_exp});
    if (we_exp) begin
      check_val("we_cycle", 32'(we_cyc), 32'(we_cyc_exp));
      check_val("we_addr", {{(32-AW){1'b0}}, we_addr_obs}, {{(32-AW){1'b0}}, addr[AW+1:2]});
      check_val("we_data", we_data_obs, new_word);
    end
    for (int c = 1; c <= lat_exp; c++) begin
      if (rdy[c]) check_val("ready_busy", 32'h1, 32'h0);
    end
    check_val("ready_after", {31'd0, rdy[lat_exp + 1]}, 32'h1);
  endtask

  initial begin
    int          first_rdy, lat;
    logic [31:0] rd;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", {31'd0, req_ready}, 32'h1);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'h0);
    check_val("rst_misalign", {31'd0, resp_misalign}, 32'h0);
    check_val("rst_mem_we", {31'd0, mem_we}, 32'h0);
    check_val("rst_mem_addr", {{(32-AW){1'b0}}, mem_addr}, 32'h0);
    check_val("rst_mem_wdata", mem_wdata, 32'h0);
    check_val("rst_rdata", resp_rdata, 32'h0);
    rst = 1'b0;

    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
    for (int i = 0; i < (1 << AW); i++) run_txn(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);

    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h80FF_7F01);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0009, 32'h0);
    run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0009, 32'h0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0008, 32'h0);
    check_val("word2_content", ref_mem[2], 32'h80FF_7F01);

    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'h1122_3344);
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_000E, 32'h0000_00AA);
    check_val("sb_merge_ram", ram[3], 32'h1122_AA44);
    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'h1122_3344);
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_000C, 32'h0000_BEEF);
    check_val("sh_merge_ram", ram[3], 32'hBEEF_3344);

    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0);

    // Reset asserted while an sb sits in WRITE must suppress the write.
    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_000E; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_pre_we", {31'd0, mem_we}, 32'h1);
    rst = 1'b1;
    #1;
    check_val("rst_we_drop", {31'd0, mem_we}, 32'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_val("rst_ram_kept", ram[3], 32'h1122_3344);
    check_val("rst_ready_after", {31'd0, req_ready}, 32'h1);
    check_val("rst_valid_after", {31'd0, resp_valid}, 32'h0);

    // Back-to-back: req_valid held from an sw straight into an lw.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0040; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    ref_mem[16] = 32'hCAFE_F00D;
    @(negedge clk);
    req_we = 1'b0;
    first_rdy = 0;
    for (int c = 1; c <= 10 && first_rdy == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (req_ready) first_rdy = c;
    end
    check_val("b2b_accept_cycle", 32'(first_rdy), 32'h3);
    @(posedge clk);
    lat = 0; rd = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (resp_valid && lat == 0) begin
        lat = c; rd = resp_rdata;
      end
    end
    check_val("b2b_lw_latency", 32'(lat), 32'h3);
    check_val("b2b_lw_data", rd, 32'hCAFE_F00D);

    for (int i = 0; i < 150; i++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, $urandom);
    end

    for (int i = 0; i < (1 << AW); i++) check_val("final_ram", ram[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
